// File: rtl/game_pkg.sv
// Shared game-state encodings and default gameplay constants used by the
// collision handler, the lives display and the renderer.
package game_pkg;

   typedef enum logic [1:0] {
      READY     = 2'd0,
      PLAYING   = 2'd1,
      HIT       = 2'd2,
      GAME_OVER = 2'd3
   } game_state_t;

   localparam int DEFAULT_START_LIVES   = 3;
   localparam int DEFAULT_INVULN_FRAMES = 60;

endpackage

// File: rtl/invuln_timer.sv
// Loadable down-counter for the post-hit invulnerability window; it stops at
// zero and reports done while the count is zero.
module invuln_timer
   import game_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             done
);

   assign done = (count == '0);

   // A load wins over a pending tick so a fresh window always starts full.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && !done) begin
         count <= count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/collision_handler.sv
// Frame-rate game-state controller: lives, post-hit invulnerability with blink,
// game over and key restart. Optional score counter under COLLISION_HANDLER_SCORE_EN.
module collision_handler
   import game_pkg::*;
#(
   parameter int LIVES_BITWIDTH  = 2,
   parameter int START_LIVES     = DEFAULT_START_LIVES,
   parameter int INVULN_FRAMES   = DEFAULT_INVULN_FRAMES,
   parameter int INVULN_BITWIDTH = 6,
   parameter int FLASH_PERIOD    = 8,
   parameter int SCORE_BITWIDTH  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      update,
   input  logic                      collision,
   input  logic                      restart,
   output logic [LIVES_BITWIDTH-1:0] lives,
   output logic [1:0]                state,
   output logic                      hit,
   output logic                      invulnerable,
   output logic                      flash,
   output logic                      game_over
`ifdef COLLISION_HANDLER_SCORE_EN
   ,
   output logic [SCORE_BITWIDTH-1:0] score
`endif
);

   localparam int FLASH_BIT = $clog2(FLASH_PERIOD);
   localparam logic [LIVES_BITWIDTH-1:0]  LIVES_INIT = LIVES_BITWIDTH'(START_LIVES);
   localparam logic [INVULN_BITWIDTH-1:0] INV_LOAD   = INVULN_BITWIDTH'(INVULN_FRAMES - 1);
   localparam logic [INVULN_BITWIDTH-1:0] INV_ONE    = INVULN_BITWIDTH'(1);
   localparam logic [INVULN_BITWIDTH-1:0] FLASH_MASK = INV_ONE << FLASH_BIT;

   // Reject parameter sets that would make the counters wrap or the blink tap vanish.
   if (START_LIVES < 1 || START_LIVES >= (1 << LIVES_BITWIDTH)) begin : g_bad_lives
      $error("collision_handler: START_LIVES out of range");
   end
   if (INVULN_FRAMES < 1 || (INVULN_FRAMES - 1) >= (1 << INVULN_BITWIDTH)) begin : g_bad_invuln
      $error("collision_handler: INVULN_FRAMES does not fit INVULN_BITWIDTH");
   end
   if (FLASH_BIT >= INVULN_BITWIDTH || (1 << FLASH_BIT) != FLASH_PERIOD) begin : g_bad_flash
      $error("collision_handler: FLASH_PERIOD must be a power of two below the counter range");
   end
   if (SCORE_BITWIDTH < 1) begin : g_bad_score
      $error("collision_handler: SCORE_BITWIDTH must be at least 1");
   end

   game_state_t                state_q;
   game_state_t                state_next;
   logic [LIVES_BITWIDTH-1:0]  lives_next;
   logic                       hit_next;
   logic                       flash_next;
   logic                       restart_q;
   logic                       start_edge;
   logic                       timer_load;
   logic [INVULN_BITWIDTH-1:0] timer_value;
   logic                       timer_enable;
   logic [INVULN_BITWIDTH-1:0] inv_count;
   logic                       inv_done;

   assign start_edge   = restart & ~restart_q;
   assign timer_enable = update && (state_q == HIT);
   assign state        = state_q;

   invuln_timer #(
      .WIDTH(INVULN_BITWIDTH)
   ) u_invuln_timer (
      .clock     (clock),
      .reset     (reset),
      .load      (timer_load),
      .load_value(timer_value),
      .enable    (timer_enable),
      .count     (inv_count),
      .done      (inv_done)
   );

   // The blink bit is taken from the count the timer will hold after this edge,
   // so flash stays registered in step with the invulnerability counter.
   always_comb begin
      state_next  = state_q;
      lives_next  = lives;
      hit_next    = 1'b0;
      flash_next  = 1'b0;
      timer_load  = 1'b0;
      timer_value = INV_LOAD;
      case (state_q)
         READY: begin
            lives_next = LIVES_INIT;
            if (start_edge) begin
               state_next = PLAYING;
            end
         end
         PLAYING: begin
            if (update && collision) begin
               hit_next = 1'b1;
               if (lives <= LIVES_BITWIDTH'(1)) begin
                  lives_next = '0;
                  state_next = GAME_OVER;
               end else begin
                  lives_next = lives - LIVES_BITWIDTH'(1);
                  timer_load = 1'b1;
                  state_next = HIT;
                  flash_next = (INV_LOAD & FLASH_MASK) != '0;
               end
            end
         end
         HIT: begin
            if (update) begin
               if (inv_done) begin
                  state_next = PLAYING;
               end else begin
                  flash_next = ((inv_count - INV_ONE) & FLASH_MASK) != '0;
               end
            end else begin
               flash_next = (inv_count & FLASH_MASK) != '0;
            end
         end
         GAME_OVER: begin
            if (start_edge) begin
               state_next  = PLAYING;
               lives_next  = LIVES_INIT;
               timer_load  = 1'b1;
               timer_value = '0;
            end
         end
         default: begin
            state_next = READY;
         end
      endcase
   end

   // restart_q powers up high so a key held through reset cannot start a game.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= READY;
         lives        <= LIVES_INIT;
         hit          <= 1'b0;
         invulnerable <= 1'b0;
         flash        <= 1'b0;
         game_over    <= 1'b0;
         restart_q    <= 1'b1;
      end else begin
         state_q      <= state_next;
         lives        <= lives_next;
         hit          <= hit_next;
         invulnerable <= (state_next == HIT);
         flash        <= flash_next;
         game_over    <= (state_next == GAME_OVER);
         restart_q    <= restart;
      end
   end

`ifdef COLLISION_HANDLER_SCORE_EN
   // Score counts frames survived; a new game clears it and it sticks at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         score <= '0;
      end else if (start_edge && (state_q == READY || state_q == GAME_OVER)) begin
         score <= '0;
      end else if (update && (state_q == PLAYING || state_q == HIT) && score != '1) begin
         score <= score + SCORE_BITWIDTH'(1);
      end
   end
`endif

endmodule
